// File: rtl/exec_seq.sv
// exec_seq: instruction sequencer that drives the external RAM and ALU to
// perform mem[op1] = mem[op1] OP src. The source is an immediate or a
// second RAM word. Carry and zero flags persist so ADC chains work across
// multi-word arithmetic.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for an instruction; latch it on accept
// RD_SRC | read mem[op2] (memory source operand)
// RD_DST | read mem[op1]; capture the source read if one is in flight
// EXEC   | capture pending read, drive ALU, register result and flags
// WRITE  | write result to mem[op1], pulse done
module exec_seq #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  localparam int OP2_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W,
  localparam int INSTR_W = 4 + ADDR_W + OP2_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               done,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_datain,
  input  logic [DATA_W-1:0]  ram_dataout,
  output logic               ram_csn,
  output logic               ram_rwn,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [2:0]         alu_sel,
  output logic               alu_cin,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_cout,
  output logic               flag_c,
  output logic               flag_z
);

  localparam logic [2:0] OPC_STO = 3'b000;
  localparam logic [2:0] OPC_ADD = 3'b001;
  localparam logic [2:0] OPC_SUB = 3'b010;
  localparam logic [2:0] OPC_NOT = 3'b110;
  localparam logic [2:0] OPC_ADC = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SRC,
    S_RD_DST,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   src_q;
  logic [DATA_W-1:0]   result_q;
  logic                flag_c_q, flag_z_q;

  logic                in_mode;
  logic [2:0]          in_opc;
  logic                in_need_src, in_need_dst;
  logic                mode_q;
  logic [2:0]          opc_q;
  logic [ADDR_W-1:0]   op1_q;
  logic [OP2_W-1:0]    op2_q;
  logic                need_src, need_dst;
  logic [DATA_W-1:0]   src_val;
  logic [DATA_W-1:0]   exec_result;

  assign in_mode     = instr[INSTR_W-1];
  assign in_opc      = instr[INSTR_W-2 -: 3];
  assign in_need_src = in_mode && (in_opc != OPC_NOT);
  assign in_need_dst = (in_opc != OPC_STO);

  assign mode_q   = instr_q[INSTR_W-1];
  assign opc_q    = instr_q[INSTR_W-2 -: 3];
  assign op1_q    = instr_q[OP2_W +: ADDR_W];
  assign op2_q    = instr_q[OP2_W-1:0];
  assign need_src = mode_q && (opc_q != OPC_NOT);
  assign need_dst = (opc_q != OPC_STO);

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;

  // Source operand in EXEC: immediate, the word captured in RD_DST, or the
  // read landing this cycle when STO skipped RD_DST.
  always_comb begin
    src_val = op2_q[DATA_W-1:0];
    if (mode_q) begin
      src_val = need_dst ? src_q : ram_dataout;
    end
    exec_result = (opc_q == OPC_STO) ? src_val : alu_out;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction latch, source capture, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      src_q    <= '0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && instr_valid) begin
        instr_q <= instr;
      end
      if (state_q == S_RD_DST && need_src) begin
        src_q <= ram_dataout;
      end
      if (state_q == S_EXEC) begin
        result_q <= exec_result;
        if (opc_q == OPC_ADD || opc_q == OPC_SUB || opc_q == OPC_ADC) begin
          flag_c_q <= alu_cout;
        end
        if (opc_q != OPC_STO) begin
          flag_z_q <= (exec_result == '0);
        end
      end
    end
  end

  // Next-state and per-state RAM/ALU drive; everything idles by default.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    ram_addr    = '0;
    ram_datain  = '0;
    ram_csn     = 1'b1;
    ram_rwn     = 1'b1;
    alu_a       = '0;
    alu_b       = '0;
    alu_sel     = 3'b000;
    alu_cin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (in_need_src)      state_d = S_RD_SRC;
          else if (in_need_dst) state_d = S_RD_DST;
          else                  state_d = S_EXEC;
        end
      end
      S_RD_SRC: begin
        ram_csn  = 1'b0;
        ram_addr = op2_q[ADDR_W-1:0];
        state_d  = need_dst ? S_RD_DST : S_EXEC;
      end
      S_RD_DST: begin
        ram_csn  = 1'b0;
        ram_addr = op1_q;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_a   = need_dst ? ram_dataout : '0;
        alu_b   = (opc_q == OPC_NOT) ? '0 : src_val;
        alu_sel = (opc_q == OPC_ADC) ? OPC_ADD : opc_q;
        alu_cin = (opc_q == OPC_ADC) ? flag_c_q : 1'b0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        ram_csn    = 1'b0;
        ram_rwn    = 1'b0;
        ram_addr   = op1_q;
        ram_datain = result_q;
        done       = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: RAM and ALU environment models, a transaction-level
// reference that predicts every output cycle from the instruction rules,
// directed cases with literal expectations, a random run, and an
// 8-bit/6-bit parameter instance for the wide ADD case.
module tb_exec_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance, DATA_W=4, ADDR_W=4 ----------------
  logic        rst, instr_valid, instr_ready, done;
  logic [11:0] instr;
  logic [3:0]  ram_addr, ram_datain, ram_dataout, alu_a, alu_b, alu_out;
  logic        ram_csn, ram_rwn, alu_cin, alu_cout, flag_c, flag_z;
  logic [2:0]  alu_sel;

  exec_seq #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .done(done), .ram_addr(ram_addr),
    .ram_datain(ram_datain), .ram_dataout(ram_dataout), .ram_csn(ram_csn),
    .ram_rwn(ram_rwn), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout),
    .flag_c(flag_c), .flag_z(flag_z)
  );

  logic [3:0] ram [16];
  logic [3:0] ram_q = 4'h0;
  assign ram_dataout = ram_q;

  // synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (!ram_csn) begin
      if (ram_rwn) ram_q <= ram[ram_addr];
      else         ram[ram_addr] <= ram_datain;
    end
  end

  // combinational ALU; SUB reports borrow on cout
  always_comb begin
    alu_out = 4'h0;
    alu_cout = 1'b0;
    case (alu_sel)
      3'd0: alu_out = alu_b;
      3'd1: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_cin};
      3'd2: {alu_cout, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd3: alu_out = alu_a & alu_b;
      3'd4: alu_out = alu_a | alu_b;
      3'd5: alu_out = alu_a ^ alu_b;
      3'd6: alu_out = ~alu_a;
      default: alu_out = 4'h0;
    endcase
  end

  // ---------------- sweep instance, DATA_W=8, ADDR_W=6 ----------------
  logic        rst2, instr_valid2, instr_ready2, done2;
  logic [17:0] instr2;
  logic [5:0]  ram_addr2;
  logic [7:0]  ram_datain2, ram_dataout2, alu_a2, alu_b2, alu_out2;
  logic        ram_csn2, ram_rwn2, alu_cin2, alu_cout2, flag_c2, flag_z2;
  logic [2:0]  alu_sel2;

  exec_seq #(.DATA_W(8), .ADDR_W(6)) dut2 (
    .clk(clk), .rst(rst2), .instr(instr2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .done(done2), .ram_addr(ram_addr2),
    .ram_datain(ram_datain2), .ram_dataout(ram_dataout2), .ram_csn(ram_csn2),
    .ram_rwn(ram_rwn2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2),
    .alu_cin(alu_cin2), .alu_out(alu_out2), .alu_cout(alu_cout2),
    .flag_c(flag_c2), .flag_z(flag_z2)
  );

  logic [7:0] ram2 [64];
  logic [7:0] ram2_q = 8'h00;
  assign ram_dataout2 = ram2_q;

  // second RAM
  always @(posedge clk) begin
    if (!ram_csn2) begin
      if (ram_rwn2) ram2_q <= ram2[ram_addr2];
      else          ram2[ram_addr2] <= ram_datain2;
    end
  end

  // second ALU (add/sub/logic subset is enough here)
  always_comb begin
    alu_out2 = 8'h00;
    alu_cout2 = 1'b0;
    case (alu_sel2)
      3'd0: alu_out2 = alu_b2;
      3'd1: {alu_cout2, alu_out2} = {1'b0, alu_a2} + {1'b0, alu_b2} + {8'h00, alu_cin2};
      3'd2: {alu_cout2, alu_out2} = {1'b0, alu_a2} - {1'b0, alu_b2};
      3'd3: alu_out2 = alu_a2 & alu_b2;
      3'd4: alu_out2 = alu_a2 | alu_b2;
      3'd5: alu_out2 = alu_a2 ^ alu_b2;
      3'd6: alu_out2 = ~alu_a2;
      default: alu_out2 = 8'h00;
    endcase
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [25:0] v;
    bit          wr;
    logic [3:0]  a;
    logic [3:0]  d;
  } rec_t;

  rec_t       q[$];
  logic [3:0] mmem [16];
  bit         fc = 1'b0, fz = 1'b0;
  int         checks = 0, errors = 0;
  int         t = 0, acc_t = 0, done_t = 0, done_prev = 0, nwrites = 0;
  logic [3:0] wr_a, wr_d, ex_a, ex_b;
  logic [2:0] ex_sel;
  logic       ex_cin;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // packed view: ready done csn rwn addr din a b sel cin c z
  function automatic logic [25:0] pack(bit rdy, bit dn, bit cs, bit rw, logic [3:0] ad,
                                       logic [3:0] di, logic [3:0] a, logic [3:0] b,
                                       logic [2:0] s, bit ci, bit c, bit z);
    return {rdy, dn, cs, rw, ad, di, a, b, s, ci, c, z};
  endfunction

  function automatic logic [11:0] mk(bit m, logic [2:0] o, logic [3:0] a, logic [3:0] b);
    return {m, o, a, b};
  endfunction

  task automatic model_accept(input logic [11:0] ins);
    bit         m;
    logic [2:0] o;
    logic [3:0] a1, a2;
    int         dv, sv, s, res;
    bit         nc, nz;
    rec_t       r;
    m = ins[11]; o = ins[10:8]; a1 = ins[7:4]; a2 = ins[3:0];
    dv = int'(mmem[a1]);
    sv = m ? int'(mmem[a2]) : int'(a2);
    s = 0; nc = fc;
    case (o)
      3'd0: res = sv;
      3'd1: begin s = dv + sv; res = s % 16; nc = (s > 15); end
      3'd2: begin res = (dv - sv + 16) % 16; nc = (dv < sv); end
      3'd3: res = dv & sv;
      3'd4: res = dv | sv;
      3'd5: res = dv ^ sv;
      3'd6: res = 15 - dv;
      default: begin s = dv + sv + int'(fc); res = s % 16; nc = (s > 15); end
    endcase
    nz = (o == 3'd0) ? fz : (res == 0);
    r.wr = 1'b0; r.a = 4'h0; r.d = 4'h0;
    if (m && o != 3'd6) begin
      r.v = pack(0, 0, 0, 1, a2, 4'h0, 4'h0, 4'h0, 3'd0, 0, fc, fz);
      q.push_back(r);
    end
    if (o != 3'd0) begin
      r.v = pack(0, 0, 0, 1, a1, 4'h0, 4'h0, 4'h0, 3'd0, 0, fc, fz);
      q.push_back(r);
    end
    r.v = pack(0, 0, 1, 1, 4'h0, 4'h0,
               (o != 3'd0) ? 4'(dv) : 4'h0,
               (o == 3'd6) ? 4'h0 : 4'(sv),
               (o == 3'd7) ? 3'd1 : o,
               (o == 3'd7) ? fc : 1'b0, fc, fz);
    q.push_back(r);
    r.v = pack(0, 1, 0, 0, a1, 4'(res), 4'h0, 4'h0, 3'd0, 0, nc, nz);
    r.wr = 1'b1; r.a = a1; r.d = 4'(res);
    q.push_back(r);
    fc = nc; fz = nz;
  endtask

  // One cycle: compare this cycle's outputs, then drive the next edge.
  task automatic cycle(input bit v, input logic [11:0] ins, input bit r, output bit acc);
    rec_t        cur;
    bit          was_idle;
    logic [25:0] obs, expv;
    @(negedge clk);
    t++;
    obs = pack(instr_ready, done, ram_csn, ram_rwn, ram_addr, ram_datain,
               alu_a, alu_b, alu_sel, alu_cin, flag_c, flag_z);
    was_idle = (q.size() == 0);
    if (was_idle) begin
      expv = pack(1, 0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 0, fc, fz);
    end else begin
      cur = q.pop_front();
      expv = cur.v;
      if (cur.wr) mmem[cur.a] = cur.d;
    end
    chk($sformatf("cyc%0d outputs", t), 32'(obs), 32'(expv));
    if (done) begin done_prev = done_t; done_t = t; wr_a = ram_addr; wr_d = ram_datain; end
    if (!ram_csn && !ram_rwn) nwrites++;
    if (ram_csn && !instr_ready) begin ex_a = alu_a; ex_b = alu_b; ex_sel = alu_sel; ex_cin = alu_cin; end
    rst = r; instr_valid = v; instr = ins;
    acc = 1'b0;
    if (r) begin
      q.delete(); fc = 1'b0; fz = 1'b0;
    end else if (was_idle && v) begin
      acc = 1'b1; acc_t = t;
      model_accept(ins);
    end
  endtask

  task automatic send(input logic [11:0] ins);
    bit acc;
    int n;
    n = 0;
    do begin cycle(1'b1, ins, 1'b0, acc); n++; end while (!acc && n < 20);
    if (!acc) chk("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin cycle(1'b0, 12'h0, 1'b0, acc); n++; end
    if (q.size() != 0) chk("drain timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic send2(input logic [17:0] ins, output logic [5:0] wa, output logic [7:0] wd,
                       output bit c, output bit z);
    bit got, d2;
    int n;
    got = 1'b0; d2 = 1'b0; n = 0;
    wa = '0; wd = '0; c = 1'b0; z = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = instr_ready2; instr_valid2 = 1'b1; instr2 = ins; n++;
    end
    @(negedge clk);
    instr_valid2 = 1'b0;
    n = 0;
    while (!d2 && n < 10) begin
      if (done2) begin
        d2 = 1'b1; wa = ram_addr2; wd = ram_datain2; c = flag_c2; z = flag_z2;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    if (!got || !d2) chk("sweep timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    int         nw0, gap;
    logic [5:0] wa2;
    logic [7:0] wd2;
    bit         c2, z2;

    for (int i = 0; i < 16; i++) begin ram[i] = 4'($urandom); mmem[i] = ram[i]; end
    ram[4] = 4'hA; ram[5] = 4'hF; ram[7] = 4'h6; ram[10] = 4'h9;
    mmem[4] = 4'hA; mmem[5] = 4'hF; mmem[7] = 4'h6; mmem[10] = 4'h9;
    for (int i = 0; i < 64; i++) ram2[i] = 8'h00;
    rst = 1'b1; instr_valid = 1'b0; instr = 12'h0;
    rst2 = 1'b1; instr_valid2 = 1'b0; instr2 = 18'h0;
    repeat (3) @(posedge clk);

    // reset state
    cycle(1'b0, 12'h0, 1'b0, acc);
    chk("reset ready", 32'(instr_ready), 32'd1);
    chk("reset csn", 32'(ram_csn), 32'd1);
    chk("reset flags", 32'({flag_c, flag_z}), 32'd0);

    // STO imm
    nw0 = nwrites;
    send(mk(0, 3'd0, 4'h3, 4'h9)); drain();
    chk("sto lat", 32'(done_t - acc_t), 32'd2);
    chk("sto wr", 32'({wr_a, wr_d}), 32'h39);
    chk("sto nwr", 32'(nwrites - nw0), 32'd1);
    chk("sto flags", 32'({flag_c, flag_z}), 32'd0);

    // ADD imm
    send(mk(0, 3'd1, 4'h4, 4'h2)); drain();
    chk("add lat", 32'(done_t - acc_t), 32'd3);
    chk("add alu", 32'({ex_a, ex_b, ex_sel}), 32'({4'hA, 4'h2, 3'd1}));
    chk("add wr", 32'({wr_a, wr_d}), 32'h4C);
    chk("add flags", 32'({flag_c, flag_z}), 32'd0);

    // carry chain
    send(mk(0, 3'd1, 4'h5, 4'h1)); drain();
    chk("carry wr", 32'({wr_a, wr_d}), 32'h50);
    chk("carry flags", 32'({flag_c, flag_z}), 32'd3);
    send(mk(0, 3'd7, 4'h5, 4'h0)); drain();
    chk("adc cin/sel", 32'({ex_cin, ex_sel}), 32'({1'b1, 3'd1}));
    chk("adc wr", 32'({wr_a, wr_d}), 32'h51);

    // XOR mem
    send(mk(1, 3'd5, 4'hA, 4'h7)); drain();
    chk("xor lat", 32'(done_t - acc_t), 32'd4);
    chk("xor alu", 32'({ex_a, ex_b, ex_sel}), 32'({4'h9, 4'h6, 3'd5}));
    chk("xor wr", 32'({wr_a, wr_d}), 32'hAF);

    // set both flags, then reset a SUB during EXEC
    send(mk(0, 3'd1, 4'h5, 4'hF)); drain();
    chk("pre-reset flags", 32'({flag_c, flag_z}), 32'd3);
    send(mk(0, 3'd2, 4'h2, 4'h1));
    nw0 = nwrites;
    cycle(1'b0, 12'h0, 1'b0, acc);
    cycle(1'b1, mk(0, 3'd0, 4'h1, 4'h1), 1'b1, acc);
    cycle(1'b0, 12'h0, 1'b0, acc);
    chk("abort ready", 32'(instr_ready), 32'd1);
    chk("abort csn", 32'(ram_csn), 32'd1);
    chk("abort flags", 32'({flag_c, flag_z}), 32'd0);
    repeat (3) cycle(1'b0, 12'h0, 1'b0, acc);
    chk("abort nwr", 32'(nwrites - nw0), 32'd0);

    // back-to-back with valid held
    send(mk(0, 3'd1, 4'h1, 4'h1));
    send(mk(0, 3'd3, 4'h2, 4'h5));
    drain();
    chk("b2b spacing", 32'(done_t - done_prev), 32'd4);

    // random traffic
    repeat (300) begin
      gap = $urandom_range(0, 2);
      repeat (gap) cycle(1'b0, 12'($urandom), 1'b0, acc);
      send(12'($urandom));
      if ($urandom_range(0, 24) == 0) begin
        repeat ($urandom_range(0, 4)) cycle(1'b0, 12'h0, 1'b0, acc);
        cycle(1'b1, 12'($urandom), 1'b1, acc);
      end
    end
    drain();
    repeat (2) cycle(1'b0, 12'h0, 1'b0, acc);
    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), 32'(ram[i]), 32'(mmem[i]));

    // wide instance: 8'hF0 + 8'h20
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    chk("w reset ready", 32'(instr_ready2), 32'd1);
    send2({1'b0, 3'd0, 6'h11, 8'hF0}, wa2, wd2, c2, z2);
    chk("w sto wr", 32'({wa2, wd2}), 32'({6'h11, 8'hF0}));
    send2({1'b0, 3'd1, 6'h11, 8'h20}, wa2, wd2, c2, z2);
    chk("w add wr", 32'({wa2, wd2}), 32'({6'h11, 8'h10}));
    chk("w add flags", 32'({c2, z2}), 32'd2);
    @(negedge clk);
    chk("w mem", 32'(ram2[17]), 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_seq.md
# exec_seq

Parametrised instruction sequencer that replaces the fixed 4-bit decoder FSM in the CPU datapath. It accepts one instruction at a time over a valid/ready handshake and sequences the external RAM and ALU ports to perform `mem[op1] = mem[op1] OP src`. The source is either an immediate or a second RAM location. It keeps carry and zero flags so that add-with-carry chains work across multi-word arithmetic.

## Interface
- `DATA_W`, default 4: RAM word / ALU operand width.
- `ADDR_W`, default 4: RAM address width.
- `OP2_W`, localparam = max(`DATA_W`, `ADDR_W`): op2 field width.
- `INSTR_W`, localparam = 1 + 3 + `ADDR_W` + `OP2_W`: instruction width. Layout is {mode, opc[2:0], op1, op2}.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `instr` in `INSTR_W`: instruction. Sampled when `instr_valid & instr_ready`.
- `instr_valid` in 1: upstream has an instruction.
- `instr_ready` out 1: sequencer idle and able to accept.
- `done` out 1: one-cycle pulse during the write cycle of each instruction.
- `ram_addr` out `ADDR_W`; `ram_datain` out `DATA_W`; `ram_dataout` in `DATA_W`.
- `ram_csn` out 1: RAM chip select, active-low.
- `ram_rwn` out 1: RAM direction, 1 = read, 0 = write.
- `alu_a`, `alu_b` out `DATA_W`; `alu_sel` out 3; `alu_cin` out 1.
- `alu_out` in `DATA_W`; `alu_cout` in 1: combinational ALU result.
- `flag_c`, `flag_z` out 1: registered carry and zero flags.

## Operation
- **Opcodes:**
  - 000 STO: result = src.
  - 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR: result = dst OP src.
  - 110 NOT: result = ~dst; src is ignored.
  - 111 ADC: result = dst + src + `flag_c`.
- **Source selection:**
  - mode=0: src = op2[`DATA_W`-1:0], an immediate.
  - mode=1: src = mem[op2[`ADDR_W`-1:0]].
  - NOT never reads a source, whatever the mode.
- **RAM reads:** one-cycle latency. `ram_dataout` is valid in the cycle after a read cycle (`ram_csn`=0, `ram_rwn`=1), and is captured in that following cycle.
- **States:**
  - IDLE: `instr_ready`=1. On accept, latch the instruction. Then go to RD_SRC if a memory source is needed, else RD_DST if dst is needed (all ops except STO), else EXEC.
  - RD_SRC: read at `ram_addr`=op2. Next state is RD_DST, or EXEC for STO.
  - RD_DST: read at `ram_addr`=op1. Capture src if the previous state was RD_SRC. Next state is EXEC.
  - EXEC: capture the pending read. Drive `alu_a`=dst, `alu_b`=src, `alu_sel`=opc (ADC drives sel 001), `alu_cin`=`flag_c` for ADC and 0 otherwise. RAM is idle. Register the result (`alu_out`, or src for STO) and update the flags at the cycle end. Next state is WRITE.
  - WRITE: `ram_csn`=0, `ram_rwn`=0, `ram_addr`=op1, `ram_datain`=result, `done`=1. Next state is IDLE.
- **Flags:**
  - `flag_c` takes `alu_cout` on ADD/SUB/ADC. It is unchanged on logic ops and STO.
  - `flag_z` takes (result==0) on every op except STO, which leaves it unchanged.
- **Outside their active states:** `alu_a`, `alu_b`, `alu_sel`, `alu_cin` = 0; `ram_datain` = 0; `ram_addr` = 0; `ram_csn` = 1; `ram_rwn` = 1.
- **Handshake:** `instr_valid` while busy is ignored. Upstream holds it until `instr_ready` is seen. The block never accepts two instructions in one IDLE cycle.
- **Arithmetic:** all arithmetic is modulo 2^`DATA_W`. Op2 bits above the field in use are ignored.

## Timing
- **Reset:** state = IDLE; `instr_ready`=1; `done`=0; flags = 0; latched instruction and result = 0; RAM and ALU outputs take their idle values. Reset mid-instruction abandons it with no write. The next cycle is IDLE with `ram_csn`=1.
- **Accept-to-done latency** (done is in cycle N+k, where N is the accept edge):
  - STO imm: k=2.
  - STO mem: k=3.
  - ALU imm or NOT: k=3.
  - ALU mem: k=4.
- **Back-to-back:** `instr_ready` rises the cycle after WRITE, so the minimum issue interval is latency+1.
- **Flags:** visible from the WRITE cycle onward, so an ADC immediately after ADD sees the new carry.
- **Simultaneous events:** `rst` with `instr_valid` resets and does not accept. A read and a write never occur in the same cycle.

## Test plan
- STO imm (mode0, op1=3, op2=9), accepted at edge N -> WRITE at N+2 with addr=3, din=9, `done`=1. Flags unchanged. Exactly one write.
- ADD imm (op1=4, op2=2, RAM returns A, bench `alu_out`=C, cout=0) -> RD_DST addr=4; EXEC a=A, b=2, sel=001; write C to addr 4; c=0, z=0.
- Carry chain: ADD imm mem[5]=F +1, bench returns 0 with cout=1 -> c=1, z=1. Then ADC op2=0 -> `alu_cin`=1 in EXEC, sel=001.
- XOR mem (mode1, op1=A, op2=7; RAM mem[7]=6, mem[A]=9, bench `alu_out`=F) -> reads addr 7 then A; a=9, b=6, sel=101; write F to A; done at N+4.
- Reset in EXEC of a SUB -> next cycle IDLE, `ram_csn`=1, no write ever issued, c=z=0, `instr_ready`=1.
- `instr_valid` held high across two queued instructions -> each accepted once, done pulses spaced by latency+1. Parameter sweep DATA_W=8, ADDR_W=6 repeats the ADD test with 8'hF0+8'h20 -> 8'h10, c=1.
